// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store unit and the debug/loader port, with read-data return routing.
module dmem_arbiter #(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  cpu_stall_cnt,
    input  logic              cnt_clr
);

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_e;

    owner_e            rr_last;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_dbg;
    logic              issue_rd;

    // Grant: a lone requester wins; on a tie the one not granted last wins.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (rst_n) begin
            if (cpu_req && (!dbg_req || rr_last == OWN_DBG)) begin
                cpu_gnt = 1'b1;
            end else if (dbg_req) begin
                dbg_gnt = 1'b1;
            end
        end
    end

    // RAM port follows the granted requester; idle cycles present CPU fields.
    always_comb begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wren  = cpu_gnt & cpu_we;
        if (dbg_gnt) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_wren  = dbg_we;
        end
    end

    assign issue_rd = (cpu_gnt & ~cpu_we) | (dbg_gnt & ~dbg_we);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last <= OWN_DBG;
        end else if (cpu_gnt) begin
            rr_last <= OWN_CPU;
        end else if (dbg_gnt) begin
            rr_last <= OWN_DBG;
        end
    end

    // Owner tags travel alongside the RAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v   <= '0;
            tag_dbg <= '0;
        end else begin
            tag_v[0]   <= issue_rd;
            tag_dbg[0] <= dbg_gnt;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_dbg[i] <= tag_dbg[i-1];
            end
        end
    end

    assign cpu_rvalid = rst_n & tag_v[RD_LAT-1] & ~tag_dbg[RD_LAT-1];
    assign dbg_rvalid = rst_n & tag_v[RD_LAT-1] &  tag_dbg[RD_LAT-1];
    assign cpu_rdata  = mem_rdata;
    assign dbg_rdata  = mem_rdata;

    // Saturating stall counter; clear wins over increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_stall_cnt <= '0;
        end else if (cnt_clr) begin
            cpu_stall_cnt <= '0;
        end else if (cpu_req && !cpu_gnt && cpu_stall_cnt != '1) begin
            cpu_stall_cnt <= cpu_stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port synchronous data memory between two requesters: the CPU load/store unit and a debug/loader port used for bench preload and board-level memory inspection.
- Sits between the CPU datapath and the data-memory RAM instance.
- Resolves simultaneous requests round-robin and routes the registered read data back to the requester that issued the read.
- Counts CPU stall cycles for the debug display.

Parameters:
ADDR_W, 11, word-address width of the data memory
DATA_W, 32, data word width
RD_LAT, 1, read latency in cycles from grant edge to mem_rdata valid (1..4)
CNT_W, 16, width of the CPU stall counter

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst_n  in  1  asynchronous active-low reset
cpu_req  in  1  CPU access request; held with its fields stable until cpu_gnt
cpu_we  in  1  1 = write, 0 = read
cpu_addr  in  ADDR_W  CPU word address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  access accepted at the next rising edge
cpu_rvalid  out  1  cpu_rdata valid this cycle
cpu_rdata  out  DATA_W  read data for the CPU
dbg_req, dbg_we, dbg_addr, dbg_wdata  in  1/1/ADDR_W/DATA_W  debug port, same rules as the CPU inputs
dbg_gnt, dbg_rvalid, dbg_rdata  out  1/1/DATA_W  debug port, same rules as the CPU outputs
mem_addr  out  ADDR_W  RAM address
mem_wren  out  1  RAM write enable
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM registered output (q)
cpu_stall_cnt  out  CNT_W  saturating count of cycles with cpu_req=1 and cpu_gnt=0
cnt_clr  in  1  synchronous clear of cpu_stall_cnt

Behaviour:
- Reset (rst_n=0, asynchronous):
  - rr_last := DBG, so the CPU wins the first tie.
  - Read-tag pipeline cleared; cpu_stall_cnt := 0.
  - cpu_gnt, dbg_gnt, mem_wren, cpu_rvalid, dbg_rvalid forced to 0 while rst_n=0.
- Grant logic (combinational from the req inputs and rr_last):
  - Only one requester active: that requester is granted.
  - Both active: the requester not in rr_last is granted.
  - Neither active: no grant; mem_wren=0; mem_addr/mem_wdata hold the CPU fields.
  - At most one gnt is high per cycle.
- Memory drive:
  - mem_addr, mem_wdata and mem_wren=we&gnt come from the granted requester in the same cycle.
  - A transaction is issued on the rising edge at the end of a cycle with gnt=1.
- rr_last updates on every issuing edge to the granted requester and holds otherwise.
- Writes complete at issue; there is no write acknowledgement beyond gnt.
- Read return:
  - A read issued at the end of cycle N pushes an owner tag into an RD_LAT-deep shift register.
  - In cycle N+RD_LAT, the matching rvalid is high for exactly one cycle.
  - Both cpu_rdata and dbg_rdata = mem_rdata and are meaningful only with rvalid.
  - Back-to-back reads pipeline fully: one issue per cycle, returns in issue order, no bubbles.
- Requester contract: req and its fields stay stable until gnt. Deasserting req before gnt abandons the request with no side effects. A new request may be presented in the cycle after gnt.
- Stall counter, evaluated each edge:
  - cnt_clr has priority: counter := 0.
  - Otherwise the counter increments when cpu_req=1 and cpu_gnt=0.
  - It saturates at 2^CNT_W-1 and does not wrap.
- Reset mid-operation: in-flight read tags are discarded, so no rvalid is produced for reads issued before reset. RAM contents are untouched.
- Same-address write then read: the arbiter only forwards; the read returns what the RAM returns.

Test Plan:
1. Reset with both reqs high: both gnt=0, both rvalid=0, mem_wren=0, cpu_stall_cnt=0. After release, cpu_gnt=1 in the first cycle.
2. CPU alone writes 0xDEADBEEF to address 10, then reads address 10 (RD_LAT=1):
   - cpu_gnt=1 in each request cycle.
   - cpu_rvalid=1 exactly one cycle after the read grant, with cpu_rdata=0xDEADBEEF.
   - dbg_rvalid stays 0.
3. Both request continuously for 4 cycles: CPU reads address 5 (=0x5), debug reads address 6 (=0x6).
   - Grants go C,D,C,D.
   - cpu_rvalid occurs in cycles 2 and 4 with 0x5; dbg_rvalid occurs in cycles 3 and 5 with 0x6.
   - cpu_stall_cnt=2.
4. RD_LAT=3: debug issues reads of addresses 1, 2, 3 on consecutive cycles. dbg_rvalid is high for 3 consecutive cycles starting 3 cycles after the first grant, returning mem[1], mem[2], mem[3] in order.
5. CPU read granted, then rst_n pulsed low before the return cycle: no cpu_rvalid is ever produced for it. The next CPU read after reset returns normally.
6. CNT_W=4, debug holding a write request and CPU read requests colliding for 40 cycles:
   - cpu_stall_cnt increments only on CPU-losing cycles, saturates at 15 and holds.
   - cnt_clr=1 for one cycle -> 0, then counting resumes.
